// File: rtl/rasterizer_pixel_walker.sv
// Raster-order walker over the screen-clipped bounding box of one set-up
// triangle. Emits LANES horizontally adjacent pixel candidates per beat with
// a lane mask, under valid/ready flow control, and can chain triangles
// back to back without an idle cycle.

package rasterizer_pixel_walker_pkg;

  // Set-up triangle as delivered by triangle setup. The walker only looks at
  // the bounding box; the rest travels along untouched for pixel evaluation.
  typedef struct packed {
    logic [15:0] tri_id;
    logic [31:0] setup_data;
    logic [15:0] bbox_min_x;
    logic [15:0] bbox_min_y;
    logic [15:0] bbox_max_x;
    logic [15:0] bbox_max_y;
  } triangle_state_t;

endpackage

module rasterizer_pixel_walker
  import rasterizer_pixel_walker_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tri_valid,
  output logic            tri_ready,
  input  triangle_state_t tri_in,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic [15:0]     pix_x_base,
  output logic [15:0]     pix_y,
  output logic [LANES-1:0] pix_lane_mask,
  output triangle_state_t pix_triangle,
  output logic            pix_last,
  output logic            tri_done,
  output logic            busy
);

  // Lane alignment: clearing the low log2(LANES) bits of x gives lane 0.
  localparam logic [15:0] ALIGN_MASK = ~16'(LANES - 1);
  localparam logic [15:0] LANES16    = 16'(LANES);
  localparam logic [16:0] LANES17    = 17'(LANES);
  localparam logic [15:0] X_LIMIT    = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_LIMIT    = 16'(SCREEN_H - 1);

  typedef enum logic {
    IDLE,
    WALK
  } state_t;

  // Clamp a bbox maximum to the last on-screen coordinate.
  function automatic logic [15:0] clip_max(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Control state (reset)
  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  // Per-triangle walk parameters (captured at accept, not reset)
  triangle_state_t tri_q, tri_d;
  logic [15:0] minx_q, minx_d;
  logic [15:0] ax_q, ax_d;
  logic [15:0] cmaxx_q, cmaxx_d;
  logic [15:0] cmaxy_q, cmaxy_d;

  // Decode of the current beat and of the incoming triangle
  logic        walk;
  logic        row_end;
  logic        last;
  logic        xfer;
  logic        accept;
  logic [15:0] in_cmaxx;
  logic [15:0] in_cmaxy;
  logic        in_empty;
  logic [16:0] lane_x;

  assign walk     = (state_q == WALK);
  // Row ends when the next lane group would start beyond the clipped max x;
  // done in 17 bits so a base near 0xFFFF cannot wrap.
  assign row_end  = (({1'b0, x_q} + LANES17) > {1'b0, cmaxx_q});
  assign last     = walk & row_end & (y_q == cmaxy_q);
  assign xfer     = walk & pix_ready;
  // A new triangle may enter while the final beat of the current one leaves.
  assign tri_ready = ~walk | (xfer & last);
  assign accept   = tri_valid & tri_ready;

  assign in_cmaxx = clip_max(tri_in.bbox_max_x, X_LIMIT);
  assign in_cmaxy = clip_max(tri_in.bbox_max_y, Y_LIMIT);
  assign in_empty = (tri_in.bbox_min_x > in_cmaxx) | (tri_in.bbox_min_y > in_cmaxy);

  assign pix_valid    = walk;
  assign busy         = walk;
  assign pix_last     = last;
  assign pix_x_base   = x_q;
  assign pix_y        = y_q;
  assign pix_triangle = tri_q;
  assign tri_done     = done_q;

  // Lane mask: each lane is live when its x lies inside [min_x, clipped max_x].
  always_comb begin
    pix_lane_mask = '0;
    lane_x        = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x = {1'b0, x_q} + 17'(i);
      pix_lane_mask[i] = walk & (lane_x >= {1'b0, minx_q}) & (lane_x <= {1'b0, cmaxx_q});
    end
  end

  // Next-state: advance on beat transfer, finish on last beat, load on accept.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    tri_d   = tri_q;
    minx_d  = minx_q;
    ax_d    = ax_q;
    cmaxx_d = cmaxx_q;
    cmaxy_d = cmaxy_q;

    if (xfer) begin
      if (last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (row_end) begin
        y_d = y_q + 16'd1;
        x_d = ax_q;
      end else begin
        x_d = x_q + LANES16;
      end
    end

    // Accept overrides the end-of-walk return to IDLE so chained triangles
    // start streaming the very next cycle.
    if (accept) begin
      if (in_empty) begin
        done_d = 1'b1;
      end else begin
        state_d = WALK;
        tri_d   = tri_in;
        minx_d  = tri_in.bbox_min_x;
        ax_d    = tri_in.bbox_min_x & ALIGN_MASK;
        cmaxx_d = in_cmaxx;
        cmaxy_d = in_cmaxy;
        x_d     = tri_in.bbox_min_x & ALIGN_MASK;
        y_d     = tri_in.bbox_min_y;
      end
    end
  end

  // Control registers, cleared by reset (an abort drops the partial walk).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Walk parameters; only meaningful while walking, so no reset needed.
  always_ff @(posedge clk) begin
    tri_q   <= tri_d;
    minx_q  <= minx_d;
    ax_q    <= ax_d;
    cmaxx_q <= cmaxx_d;
    cmaxy_q <= cmaxy_d;
  end

endmodule
